// File: rtl/traffic_display_scan.sv
// -----------------------------------------------------------------------------
// traffic_display_scan
//
// Purpose
//   Drives a 4-digit multiplexed common-anode 7-segment display and the lamp
//   LEDs from the traffic_light controller's countdown and lamp outputs.
//   Once per frame, at the start of slot 0, the four BCD digits and both lamp
//   states are captured together. The display then shows only that capture
//   for the whole frame, so a countdown tick in the middle of a frame cannot
//   tear the picture. Any captured digit above 9 is shown as a dash and sets
//   a sticky error flag.
//
// Optional feature
//   TD_BLINK_EN : when defined, a pair of digits {H,L} whose value lies in
//                 1..BLINK_THR blinks. Each blink half-period lasts
//                 BLINK_DIV frames. When not defined, there is no frame
//                 counter, and BLINK_DIV and BLINK_THR have no effect.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (must be >= BLANK_CYC+2)
//   BLANK_CYC  cycles at the start of each slot with all anodes off (>= 1)
//   BLINK_DIV  frames per blink half-period (TD_BLINK_EN only)
//   BLINK_THR  BCD pair threshold for blinking (TD_BLINK_EN only)
//
// Ports
//   Clk                       system clock, rising edge
//   R                         asynchronous active-low reset
//   A_Time_L/H, B_Time_L/H    BCD countdown digits (units/tens) for A and B
//   A_light, B_light          lamp state per direction: 1 = green, 0 = red
//   seg[6:0]                  segments {g,f,e,d,c,b,a}, active-high
//   an[3:0]                   digit enables, active-low:
//                             [0]=A_L [1]=A_H [2]=B_L [3]=B_H
//   A_grn/A_red/B_grn/B_red   lamp LEDs, active-high
//   bcd_err                   sticky flag: a captured digit was > 9
// -----------------------------------------------------------------------------
module traffic_display_scan #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 64,
  parameter logic [7:0]  BLINK_THR = 8'h03
) (
  input  logic       Clk,
  input  logic       R,
  input  logic [3:0] A_Time_L,
  input  logic [3:0] A_Time_H,
  input  logic [3:0] B_Time_L,
  input  logic [3:0] B_Time_H,
  input  logic       A_light,
  input  logic       B_light,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       A_grn,
  output logic       A_red,
  output logic       B_grn,
  output logic       B_red,
  output logic       bcd_err
);

  localparam int unsigned       PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_BLANK = PRE_W'(BLANK_CYC);

  // scan position
  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic             slot_end;
  logic             frame_start;
  logic             frame_end;

  // frame snapshot
  logic [3:0] snap_a_l;
  logic [3:0] snap_a_h;
  logic [3:0] snap_b_l;
  logic [3:0] snap_b_h;
  logic       snap_a_light;
  logic       snap_b_light;
  logic       snap_taken;

  // slot decode
  logic [3:0] cur_digit;
  logic       lead_zero;
  logic       blink_blank;
  logic       snap_bad;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  assign slot_end    = (pre == PRE_LAST);
  assign frame_start = (pre == '0) && (idx == 2'd0);
  assign frame_end   = slot_end && (idx == 2'd3);

  // ---------------------------------------------------------------------------
  // Slot prescaler and digit index. idx wraps from 3 to 0 by overflow.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Whole-frame snapshot. snap_taken marks the cycle after a capture, which is
  // when the lamp LEDs pick up the new lamp state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      snap_a_l     <= 4'd0;
      snap_a_h     <= 4'd0;
      snap_b_l     <= 4'd0;
      snap_b_h     <= 4'd0;
      snap_a_light <= 1'b0;
      snap_b_light <= 1'b0;
      snap_taken   <= 1'b0;
    end else begin
      snap_taken <= frame_start;
      if (frame_start) begin
        snap_a_l     <= A_Time_L;
        snap_a_h     <= A_Time_H;
        snap_b_l     <= B_Time_L;
        snap_b_h     <= B_Time_H;
        snap_a_light <= A_light;
        snap_b_light <= B_light;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink. The blink phase flips after every BLINK_DIV complete
  // frames. Because it only changes at a frame boundary, a frame is never
  // split between the visible and the blanked phase.
  // ---------------------------------------------------------------------------
`ifdef TD_BLINK_EN
  localparam int unsigned       FCNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_DIV - 1);

  logic [FCNT_W-1:0] fcnt;
  logic              blink_ph;
  logic [7:0]        pair_val;

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      fcnt     <= '0;
      blink_ph <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FCNT_MAX) begin
        fcnt     <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  // Both digits of a direction blink together, so the pair value is chosen
  // by direction (idx[1]), not by the digit currently being scanned.
  always_comb begin
    pair_val    = idx[1] ? {snap_b_h, snap_b_l} : {snap_a_h, snap_a_l};
    blink_blank = blink_ph && (pair_val != 8'h00) && (pair_val <= BLINK_THR);
  end
`else
  logic unused_blink_cfg;

  assign blink_blank      = 1'b0;
  assign unused_blink_cfg = frame_end ^ (^{BLINK_THR, 32'(BLINK_DIV)});
`endif

  // ---------------------------------------------------------------------------
  // Digit selection and segment decode
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;   // non-BCD digit shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    cur_digit = snap_a_l;
    case (idx)
      2'd0:    cur_digit = snap_a_l;
      2'd1:    cur_digit = snap_a_h;
      2'd2:    cur_digit = snap_b_l;
      default: cur_digit = snap_b_h;
    endcase
  end

  // Odd slots hold the tens digits; a tens digit of zero is not lit.
  assign lead_zero = idx[0] && (cur_digit == 4'd0);

  assign snap_bad = (snap_a_l > 4'd9) || (snap_a_h > 4'd9) ||
                    (snap_b_l > 4'd9) || (snap_b_h > 4'd9);

  // During the first BLANK_CYC cycles of a slot every anode is off. This gives
  // the previous digit's segments time to discharge before the next anode is
  // driven, which avoids ghosting.
  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h00;
    if (pre >= PRE_BLANK) begin
      an_next = ~(4'b0001 << idx);
      if (!lead_zero && !blink_blank) begin
        seg_next = seg_decode(cur_digit);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      seg     <= 7'h00;
      an      <= 4'hF;
      A_grn   <= 1'b0;
      A_red   <= 1'b0;
      B_grn   <= 1'b0;
      B_red   <= 1'b0;
      bcd_err <= 1'b0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      if (snap_taken) begin
        A_grn <= snap_a_light;
        A_red <= ~snap_a_light;
        B_grn <= snap_b_light;
        B_red <= ~snap_b_light;
      end
      bcd_err <= bcd_err | snap_bad;
    end
  end

endmodule

// File: tb/tb_traffic_display_scan.sv
// -----------------------------------------------------------------------------
// Testbench for traffic_display_scan (SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=2).
// The reference model works from the absolute cycle count since reset release:
// slot = (p / SCAN_DIV) % 4, offset = p % SCAN_DIV, frame = p / (4*SCAN_DIV),
// and it keeps the digits captured at each frame start.
// -----------------------------------------------------------------------------
module tb_traffic_display_scan;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int BDIV  = 2;
  localparam int FRAME = 4 * SLOT;
  localparam logic [7:0] THR = 8'h03;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                          7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                          7'h40, 7'h40, 7'h40, 7'h40};

  logic       clk = 1'b0;
  logic       r_n;
  logic [3:0] a_l, a_h, b_l, b_h;
  logic       la, lb;
  logic [6:0] seg;
  logic [3:0] an;
  logic       a_grn, a_red, b_grn, b_red, bcd_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state
  logic [3:0] m_snap [4];
  logic       m_la, m_lb;
  logic [3:0] m_led;
  logic       m_err;

  always #5 clk = ~clk;

  traffic_display_scan #(
    .SCAN_DIV (SLOT),
    .BLANK_CYC(BLANK),
    .BLINK_DIV(BDIV),
    .BLINK_THR(THR)
  ) dut (
    .Clk     (clk),
    .R       (r_n),
    .A_Time_L(a_l),
    .A_Time_H(a_h),
    .B_Time_L(b_l),
    .B_Time_H(b_h),
    .A_light (la),
    .B_light (lb),
    .seg     (seg),
    .an      (an),
    .A_grn   (a_grn),
    .A_red   (a_red),
    .B_grn   (b_grn),
    .B_red   (b_red),
    .bcd_err (bcd_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    cyc   = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    m_la  = 1'b0;
    m_lb  = 1'b0;
    m_led = 4'd0;
    m_err = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_an",  8'(an),      8'h0F);
    chk("rst_seg", 8'(seg),     8'h00);
    chk("rst_led", 8'({a_grn, a_red, b_grn, b_red}), 8'h00);
    chk("rst_err", 8'(bcd_err), 8'h00);
  endtask

  task automatic set_in(input logic [3:0] ah, input logic [3:0] al,
                        input logic [3:0] bh, input logic [3:0] bl,
                        input logic nla, input logic nlb);
    a_h = ah; a_l = al; b_h = bh; b_l = bl; la = nla; lb = nlb;
  endtask

  // One clock edge: predict the outputs from the state before the edge,
  // advance the model, then sample the DUT 1 ns after the edge.
  task automatic step();
    int         p, slot, off, frm;
    logic [3:0] d;
    logic [7:0] pair;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_err, bad;
    @(posedge clk);
    cyc++;
    p    = cyc - 1;
    slot = (p / SLOT) % 4;
    off  = p % SLOT;
    frm  = p / FRAME;
    exp_an  = 4'hF;
    exp_seg = 7'h00;
    if (off >= BLANK) begin
      exp_an = ~(4'b0001 << slot);
      d = m_snap[slot];
      if ((slot % 2 == 1) && d == 4'd0) exp_seg = 7'h00;
      else exp_seg = SEG_TAB[d];
`ifdef TD_BLINK_EN
      pair = (slot < 2) ? {m_snap[1], m_snap[0]} : {m_snap[3], m_snap[2]};
      if (((frm / BDIV) % 2 == 1) && pair != 8'h00 && pair <= THR) exp_seg = 7'h00;
`else
      pair = 8'h00;
`endif
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) if (m_snap[i] > 4'd9) bad = 1'b1;
    exp_err = m_err | bad;
    if (p % FRAME == 1) m_led = {m_la, ~m_la, m_lb, ~m_lb};
    if (p % FRAME == 0) begin
      m_snap[0] = a_l; m_snap[1] = a_h; m_snap[2] = b_l; m_snap[3] = b_h;
      m_la = la; m_lb = lb;
    end
    m_err = exp_err;
    #1;
    chk("an",  8'(an),  8'(exp_an));
    chk("seg", 8'(seg), 8'(exp_seg));
    chk("led", 8'({a_grn, a_red, b_grn, b_red}), 8'(m_led));
    chk("bcd_err", 8'(bcd_err), 8'(exp_err));
    if (frm < 0) $display("frame %0d", frm);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_slot(input int s);
    int guard;
    guard = 0;
    while ((((cyc - 1) % FRAME) / SLOT != s) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      n_err++;
      $error("FAIL slot_reach cyc=%0d observed=timeout expected=slot %0d", cyc, s);
    end
  endtask

  initial begin
    // 1: reset with arbitrary inputs, then release
    r_n = 1'b0;
    set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();

    // 2: steady scan A=25 B=07, A green / B red
    set_in(4'd2, 4'd5, 4'd0, 4'd7, 1'b1, 1'b0);
    r_n = 1'b1;
    run(2 * FRAME);

    // 3: tearing - change A units while slot 2 is displayed
    run_to_slot(2);
    run(3);
    a_l = 4'd4;
    run(2 * FRAME);

    // randomized inputs changing at arbitrary cycles
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: a_l = 4'($urandom_range(0, 9));
          1: a_h = 4'($urandom_range(0, 9));
          2: b_l = 4'($urandom_range(0, 9));
          3: b_h = 4'($urandom_range(0, 9));
          4: la  = ~la;
          default: lb = ~lb;
        endcase
      end
      step();
    end

    // 4: invalid digit, then back to valid; error flag stays set
    set_in(4'd1, 4'd0, 4'hC, 4'd0, 1'b0, 1'b1);
    run(2 * FRAME);
    b_h = 4'd0;
    run(2 * FRAME);
    chk("err_sticky", 8'(bcd_err), 8'h01);

    // 5: reset pulse in the middle of slot 2
    run_to_slot(2);
    run(3);
    r_n = 1'b0;
    #1;
    chk_reset_state();
    @(posedge clk);
    #1;
    chk_reset_state();
    r_n = 1'b1;
    model_reset();
    run(2 * FRAME);

    // 6: blink candidates; pair A=03 in range, B=12 out of range, then A=00
    set_in(4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0);
    run(8 * FRAME);
    set_in(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1);
    run(4 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
